// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core pipeline: write-back source encodings,
// MEM-stage handshake states and the link-address offset.
package cpu_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam int LINK_OFFSET = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } mem_state_t;

    // Loads are identified by their write-back source, stores by their own flag.
    function automatic logic is_mem_op(input logic mem_write, input logic [1:0] wb_src);
        return mem_write | (wb_src == WB_LOAD);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears every field, including the
// register-file write enable, so nothing is retired that cycle.
module mem_wb_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_bubble,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [4:0]        i_num_write,
    input  logic              i_reg_write,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_wdata,
    output logic [4:0]        o_num_write,
    output logic              o_reg_write
);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_wdata;
    logic [4:0]        r_num_write;
    logic              r_reg_write;

    always_ff @(posedge clock) begin
        if (reset || i_bubble) begin
            r_pc        <= '0;
            r_wdata     <= '0;
            r_num_write <= '0;
            r_reg_write <= 1'b0;
        end else begin
            r_pc        <= i_pc;
            r_wdata     <= i_wdata;
            r_num_write <= i_num_write;
            r_reg_write <= i_reg_write;
        end
    end

    assign o_pc        = r_pc;
    assign o_wdata     = r_wdata;
    assign o_num_write = r_num_write;
    assign o_reg_write = r_reg_write;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage MIPS core: data-memory req/ack handshake with
// upstream stall, misalignment and timeout detection, and the MEM/WB register.
//   state | meaning
//   IDLE  | no access outstanding; zero-wait accesses complete here
//   WAIT  | request issued, not yet acknowledged; pipeline stalled
//   ERR   | bus timeout seen; memory ops become bubbles until reset
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_pc,
    input  logic [DATA_W-1:0] mem_b,
    input  logic [DATA_W-1:0] mem_c,
    input  logic [4:0]        mem_num_write,
    input  logic              mem_mem_write,
    input  logic              mem_reg_write,
    input  logic [1:0]        mem_s_data_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic [DATA_W-1:0] wb_pc,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [4:0]        wb_num_write,
    output logic              wb_reg_write,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_misalign_err;
    logic              r_bus_err;

    logic              w_mem_op;
    logic              w_aligned;
    logic              w_misalign;
    logic              w_timeout;
    logic              w_req;
    logic              w_stall;
    logic              w_bubble;
    logic [DATA_W-1:0] w_wb_wdata;

    assign w_mem_op   = is_mem_op(mem_mem_write, mem_s_data_write);
    assign w_aligned  = (mem_c[1:0] == 2'b00);
    // Inputs are frozen while in WAIT, so misalignment is only judged on entry.
    assign w_misalign = w_mem_op & ~w_aligned & (r_state != WAIT);
    assign w_timeout  = (r_state == WAIT) & ~dmem_ack & (r_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req & ~dmem_ack) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    w_state_next = IDLE;
                end else if (w_timeout) begin
                    w_state_next = ERR;
                end
            end
            ERR:     w_state_next = ERR;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        case (r_state)
            IDLE:    w_req = w_mem_op & w_aligned;
            WAIT:    w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
        // The expiry cycle releases the pipeline; the access retires as a bubble.
        w_stall = w_req & ~dmem_ack & ~w_timeout;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= (w_req & ~dmem_ack) ? CNT_W'(1) : '0;
        end else if ((r_state == WAIT) & ~dmem_ack & ~w_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            if (w_misalign) begin
                r_misalign_err <= 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_wb_wdata = mem_c;
        case (mem_s_data_write)
            WB_LOAD: w_wb_wdata = dmem_rdata;
            WB_LINK: w_wb_wdata = mem_pc + DATA_W'(LINK_OFFSET);
            default: w_wb_wdata = mem_c;
        endcase
    end

    assign w_bubble = w_stall | w_misalign | w_timeout | ((r_state == ERR) & w_mem_op);

    mem_wb_reg #(
        .DATA_W(DATA_W)
    ) u_mem_wb_reg (
        .clock       (clock),
        .reset       (reset),
        .i_bubble    (w_bubble),
        .i_pc        (mem_pc),
        .i_wdata     (w_wb_wdata),
        .i_num_write (mem_num_write),
        .i_reg_write (mem_reg_write),
        .o_pc        (wb_pc),
        .o_wdata     (wb_wdata),
        .o_num_write (wb_num_write),
        .o_reg_write (wb_reg_write)
    );

    assign dmem_req     = w_req;
    assign dmem_we      = w_req & mem_mem_write;
    assign dmem_addr    = mem_c;
    assign dmem_wdata   = mem_b;
    assign stall        = w_stall;
    assign misalign_err = r_misalign_err;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand sequences for multi-cycle
// corners, and random instructions checked against a per-instruction model.
module tb_mem_wb_stage;
    import cpu_pkg::*;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_pc, mem_b, mem_c, dmem_rdata;
    logic [4:0]  mem_num_write;
    logic        mem_mem_write, mem_reg_write, dmem_ack;
    logic [1:0]  mem_s_data_write;
    logic        dmem_req, dmem_we, stall, wb_reg_write, misalign_err, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_pc, wb_wdata;
    logic [4:0]  wb_num_write;

    int checks   = 0;
    int failures = 0;
    bit m_mis    = 1'b0;
    bit m_bus    = 1'b0;

    always #5 clock = ~clock;

    mem_wb_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .mem_pc(mem_pc), .mem_b(mem_b), .mem_c(mem_c),
        .mem_num_write(mem_num_write), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_s_data_write(mem_s_data_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .wb_pc(wb_pc), .wb_wdata(wb_wdata),
        .wb_num_write(wb_num_write), .wb_reg_write(wb_reg_write),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] pc, b, c;
        logic [4:0]  rd;
        logic        mw, rw;
        logic [1:0]  src;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req, exp_stall, exp_we;
        logic [31:0] exp_pc, exp_wdata;
        logic [4:0]  exp_rd;
        logic        exp_rw, exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc, b, c;
        logic [4:0]  rd;
        logic        mw, rw;
        logic [1:0]  src;
        logic [31:0] rdata;
        int          delay;
        logic        stray;
    } ins_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] pc, b, c, input logic [4:0] rd,
                          input logic mw, rw, input logic [1:0] src);
        mem_pc = pc; mem_b = b; mem_c = c; mem_num_write = rd;
        mem_mem_write = mw; mem_reg_write = rw; mem_s_data_write = src;
    endtask

    function automatic vec_t mkvec(
        logic [31:0] pc, b, c, logic [4:0] rd, logic mw, rw, logic [1:0] src,
        logic ack, logic [31:0] rdata, logic e_req, e_stall, e_we,
        logic [31:0] e_pc, e_wdata, logic [4:0] e_rd, logic e_rw, e_mis);
        vec_t v;
        v.pc = pc; v.b = b; v.c = c; v.rd = rd; v.mw = mw; v.rw = rw; v.src = src;
        v.ack = ack; v.rdata = rdata; v.exp_req = e_req; v.exp_stall = e_stall;
        v.exp_we = e_we; v.exp_pc = e_pc; v.exp_wdata = e_wdata; v.exp_rd = e_rd;
        v.exp_rw = e_rw; v.exp_mis = e_mis;
        return v;
    endfunction

    // One instruction through MEM: stall cycles, then its expected MEM/WB contents.
    task automatic run_ins(input ins_t t, input string tag);
        logic        is_mem, mis, issues;
        int          d;
        logic [31:0] e_data;
        is_mem = t.mw | (t.src == 2'b01);
        mis    = is_mem & (t.c[1:0] != 2'b00);
        issues = is_mem & ~mis & ~m_bus;
        d      = issues ? t.delay : 0;
        case (t.src)
            2'b01:   e_data = t.rdata;
            2'b10:   e_data = t.pc + 32'd8;
            default: e_data = t.c;
        endcase
        for (int k = 0; k <= d; k++) begin
            set_in(t.pc, t.b, t.c, t.rd, t.mw, t.rw, t.src);
            dmem_ack   = issues ? (k == d) : t.stray;
            dmem_rdata = (k == d) ? t.rdata : ~t.rdata;
            @(negedge clock);
            chk($sformatf("%s req k%0d", tag, k), dmem_req, issues);
            chk($sformatf("%s stall k%0d", tag, k), stall, issues && (k < d));
            if (issues) begin
                chk($sformatf("%s we", tag), dmem_we, t.mw);
                chk($sformatf("%s addr", tag), dmem_addr, t.c);
                chk($sformatf("%s wdata_out", tag), dmem_wdata, t.b);
            end
            @(posedge clock); #1;
            if (k < d) begin
                chk($sformatf("%s bubble rw k%0d", tag, k), wb_reg_write, 1'b0);
                chk($sformatf("%s bubble pc k%0d", tag, k), wb_pc, 32'h0);
            end else begin
                m_mis = m_mis | mis;
                if (mis || (is_mem && m_bus)) begin
                    chk($sformatf("%s wb_rw", tag), wb_reg_write, 1'b0);
                    chk($sformatf("%s wb_pc", tag), wb_pc, 32'h0);
                    chk($sformatf("%s wb_wdata", tag), wb_wdata, 32'h0);
                    chk($sformatf("%s wb_rd", tag), wb_num_write, 5'd0);
                end else begin
                    chk($sformatf("%s wb_rw", tag), wb_reg_write, t.rw);
                    chk($sformatf("%s wb_pc", tag), wb_pc, t.pc);
                    chk($sformatf("%s wb_wdata", tag), wb_wdata, e_data);
                    chk($sformatf("%s wb_rd", tag), wb_num_write, t.rd);
                end
                chk($sformatf("%s misalign", tag), misalign_err, m_mis);
                chk($sformatf("%s bus_err", tag), bus_err, m_bus);
            end
        end
    endtask

    function automatic ins_t mkins(logic [31:0] pc, b, c, logic [4:0] rd, logic mw, rw,
                                   logic [1:0] src, logic [31:0] rdata, int delay);
        ins_t t;
        t.pc = pc; t.b = b; t.c = c; t.rd = rd; t.mw = mw; t.rw = rw; t.src = src;
        t.rdata = rdata; t.delay = delay; t.stray = 1'b0;
        return t;
    endfunction

    initial begin
        ins_t t;
        int   sel;

        tbl[0] = mkvec(32'h400, 32'h55, 32'h1234, 5'd5, 0, 1, 2'b00, 0, 32'h0,
                       0, 0, 0, 32'h400, 32'h1234, 5'd5, 1, 0);
        tbl[1] = mkvec(32'h404, 32'h0, 32'hA5A5, 5'd7, 0, 1, 2'b00, 1, 32'h11111111,
                       0, 0, 0, 32'h404, 32'hA5A5, 5'd7, 1, 0);
        tbl[2] = mkvec(32'h408, 32'hCAFE, 32'h200, 5'd0, 1, 0, 2'b00, 1, 32'h0,
                       1, 0, 1, 32'h408, 32'h200, 5'd0, 0, 0);
        tbl[3] = mkvec(32'h40C, 32'h0, 32'h300, 5'd9, 0, 1, 2'b01, 1, 32'h12345678,
                       1, 0, 0, 32'h40C, 32'h12345678, 5'd9, 1, 0);
        tbl[4] = mkvec(32'hFFFFFFFC, 32'h0, 32'h77, 5'd31, 0, 1, 2'b10, 0, 32'h0,
                       0, 0, 0, 32'hFFFFFFFC, 32'h4, 5'd31, 1, 0);
        tbl[5] = mkvec(32'h410, 32'h0, 32'hBEEF, 5'd3, 0, 1, 2'b11, 0, 32'h0,
                       0, 0, 0, 32'h410, 32'hBEEF, 5'd3, 1, 0);
        tbl[6] = mkvec(32'h414, 32'h0, 32'h102, 5'd4, 0, 1, 2'b01, 0, 32'h0,
                       0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 1);
        tbl[7] = mkvec(32'h418, 32'h0, 32'h42, 5'd6, 0, 1, 2'b00, 0, 32'h0,
                       0, 0, 0, 32'h418, 32'h42, 5'd6, 1, 1);
        tbl[8] = mkvec(32'h41C, 32'h99, 32'h203, 5'd0, 1, 0, 2'b00, 1, 32'h0,
                       0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 1);

        reset = 1'b1;
        set_in(32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 2'b00);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("reset req", dmem_req, 1'b0);
        chk("reset stall", stall, 1'b0);
        @(posedge clock); #1;
        chk("reset wb_pc", wb_pc, 32'h0);
        chk("reset wb_wdata", wb_wdata, 32'h0);
        chk("reset wb_rd", wb_num_write, 5'd0);
        chk("reset wb_rw", wb_reg_write, 1'b0);
        chk("reset misalign", misalign_err, 1'b0);
        chk("reset bus_err", bus_err, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].pc, tbl[i].b, tbl[i].c, tbl[i].rd, tbl[i].mw, tbl[i].rw, tbl[i].src);
            dmem_ack = tbl[i].ack; dmem_rdata = tbl[i].rdata;
            @(negedge clock);
            chk($sformatf("tbl%0d req", i), dmem_req, tbl[i].exp_req);
            chk($sformatf("tbl%0d stall", i), stall, tbl[i].exp_stall);
            if (tbl[i].exp_req) begin
                chk($sformatf("tbl%0d we", i), dmem_we, tbl[i].exp_we);
                chk($sformatf("tbl%0d addr", i), dmem_addr, tbl[i].c);
                chk($sformatf("tbl%0d wdata_out", i), dmem_wdata, tbl[i].b);
            end
            @(posedge clock); #1;
            chk($sformatf("tbl%0d wb_pc", i), wb_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d wb_wdata", i), wb_wdata, tbl[i].exp_wdata);
            chk($sformatf("tbl%0d wb_rd", i), wb_num_write, tbl[i].exp_rd);
            chk($sformatf("tbl%0d wb_rw", i), wb_reg_write, tbl[i].exp_rw);
            chk($sformatf("tbl%0d misalign", i), misalign_err, tbl[i].exp_mis);
        end
        m_mis = 1'b1;

        // Load acknowledged after three wait cycles.
        run_ins(mkins(32'h500, 32'h0, 32'h100, 5'd10, 0, 1, 2'b01, 32'hDEADBEEF, 3), "load3");

        // Reset during a five-cycle wait abandons the access.
        for (int k = 0; k < 3; k++) begin
            set_in(32'h600, 32'h0, 32'h180, 5'd12, 0, 1, 2'b01);
            dmem_ack = 1'b0; dmem_rdata = 32'h0;
            @(negedge clock);
            chk($sformatf("rstwait stall k%0d", k), stall, 1'b1);
            @(posedge clock); #1;
            chk($sformatf("rstwait bubble k%0d", k), wb_reg_write, 1'b0);
        end
        reset = 1'b1;
        set_in(32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 2'b00);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rstwait wb_pc", wb_pc, 32'h0);
        chk("rstwait wb_wdata", wb_wdata, 32'h0);
        chk("rstwait wb_rd", wb_num_write, 5'd0);
        chk("rstwait wb_rw", wb_reg_write, 1'b0);
        chk("rstwait misalign", misalign_err, 1'b0);
        chk("rstwait bus_err", bus_err, 1'b0);
        @(negedge clock);
        chk("rstwait req after", dmem_req, 1'b0);
        chk("rstwait stall after", stall, 1'b0);
        @(posedge clock); #1;
        m_mis = 1'b0; m_bus = 1'b0;
        run_ins(mkins(32'h604, 32'h0, 32'h184, 5'd12, 0, 1, 2'b01, 32'h0BADF00D, 2), "postrst");

        // Random instruction mix, ack delays kept below the timeout.
        for (int n = 0; n < 80; n++) begin
            t.pc = $urandom; t.b = $urandom; t.c = $urandom;
            t.rd = 5'($urandom); t.rw = 1'($urandom); t.rdata = $urandom;
            t.delay = $urandom_range(0, 5); t.stray = 1'($urandom);
            t.mw = 1'b0; t.src = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                if (t.src == 2'b01) t.src = 2'b00;
            end else if (sel <= 5) begin
                t.src = 2'b01; t.c[1:0] = 2'b00;
            end else if (sel <= 7) begin
                t.mw = 1'b1; t.src = 2'b00; t.c[1:0] = 2'b00;
            end else begin
                t.mw = 1'($urandom); t.src = t.mw ? 2'b00 : 2'b01;
                t.c[1:0] = 2'($urandom_range(1, 3));
            end
            run_ins(t, $sformatf("rnd%0d", n));
        end

        // Unacknowledged load runs into the timeout.
        for (int k = 0; k <= TIMEOUT; k++) begin
            set_in(32'h700, 32'h0, 32'h240, 5'd13, 0, 1, 2'b01);
            dmem_ack = 1'b0; dmem_rdata = 32'h0;
            @(negedge clock);
            chk($sformatf("tmo req k%0d", k), dmem_req, 1'b1);
            chk($sformatf("tmo stall k%0d", k), stall, k < TIMEOUT);
            @(posedge clock); #1;
            chk($sformatf("tmo wb_rw k%0d", k), wb_reg_write, 1'b0);
            chk($sformatf("tmo bus_err k%0d", k), bus_err, k == TIMEOUT);
        end
        m_bus = 1'b1;
        run_ins(mkins(32'h704, 32'h0, 32'h280, 5'd14, 0, 1, 2'b01, 32'h13572468, 1), "err_load");
        run_ins(mkins(32'h708, 32'h77, 32'h2C0, 5'd0, 1, 0, 2'b00, 32'h0, 0), "err_store");
        run_ins(mkins(32'h70C, 32'h0, 32'h3333, 5'd15, 0, 1, 2'b00, 32'h0, 0), "err_alu");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumes the EXE/MEM pipeline-register outputs of the 5-stage MIPS core and performs the memory access on the data-memory bus.
- Acts as the responder side of the EXE/MEM interface: it executes the load or store over a req/ack handshake and stalls upstream stages while the access is outstanding.
- Registers the write-back result into the MEM/WB pipeline register.
- Detects misaligned word accesses and bus timeouts.

Parameters:
- DATA_W, 32, data/address width.
- TIMEOUT, 16, maximum cycles waiting for dmem_ack before a bus error is declared.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  reset
- mem_pc  input  DATA_W  PC of the instruction in MEM
- mem_b  input  DATA_W  store data
- mem_c  input  DATA_W  ALU result / memory address
- mem_num_write  input  5  destination register number
- mem_mem_write  input  1  instruction is a store
- mem_reg_write  input  1  instruction writes the register file
- mem_s_data_write  input  2  WB source: 00 ALU result, 01 load data, 10 pc+8 (link), 11 reserved (treated as 00)
- dmem_req  output  1  memory request valid
- dmem_we  output  1  request is a write
- dmem_addr  output  DATA_W  word address (= mem_c)
- dmem_wdata  output  DATA_W  store data (= mem_b)
- dmem_rdata  input  DATA_W  load data, valid when dmem_ack=1
- dmem_ack  input  1  request completed this cycle
- stall  output  1  hold PC, IF/ID, ID/EXE and EXE/MEM this cycle
- wb_pc, wb_wdata  output  DATA_W  MEM/WB register: PC and write-back data
- wb_num_write  output  5  MEM/WB destination register
- wb_reg_write  output  1  MEM/WB register-file write enable
- misalign_err  output  1  sticky misaligned-access flag
- bus_err  output  1  sticky timeout flag

Behaviour:
- Reset: reset is synchronous and active-high. It clears all wb_* outputs, misalign_err, bus_err and the timeout counter to 0, and sets state to IDLE. dmem_req and stall are therefore 0 after reset.
- mem_op = mem_mem_write | (mem_s_data_write==01); aligned = (mem_c[1:0]==00).
- FSM states:
  - IDLE: holds when there is no access in progress.
  - WAIT: a request is outstanding and unacknowledged.
  - ERR: terminal; left only by reset.
- dmem_req (combinational) = (state==IDLE & mem_op & aligned) | state==WAIT.
- dmem_we = mem_mem_write whenever dmem_req=1.
- dmem_addr and dmem_wdata pass through combinationally.
- stall (combinational) = dmem_req & ~dmem_ack.
- Zero-wait memory: ack in the same cycle as the request completes the access with no stall.
- IDLE -> WAIT: dmem_req & ~dmem_ack; the counter loads 1.
- WAIT -> IDLE: on dmem_ack.
- WAIT, no ack: the counter increments. When the counter reaches TIMEOUT without an ack:
  - bus_err <= 1 and state moves to ERR;
  - a bubble is loaded into MEM/WB;
  - stall drops for that cycle.
- ERR: dmem_req = 0 and stall = 0. Any further mem_op produces bubbles; non-memory instructions flow normally.
- MEM/WB update, every cycle:
  - If stall=1: load a bubble (wb_reg_write=0, all other wb_* fields = 0).
  - Otherwise load mem_pc and mem_num_write.
  - wb_reg_write = mem_reg_write, except it is forced to 0 on a misaligned access or timeout.
  - wb_wdata by source: 00 → mem_c; 01 → dmem_rdata sampled on the ack cycle; 10 → mem_pc+8, mod 2^DATA_W.
- Misaligned mem_op:
  - no request is issued and stall = 0;
  - misalign_err <= 1 (sticky until reset);
  - a bubble is loaded into MEM/WB;
  - stores never reach memory.
- Ack in IDLE without a request is ignored. Ack asserted coincidentally with timeout expiry wins: the access completes normally.
- Reset mid-access (state WAIT): next cycle state = IDLE and dmem_req = 0. The in-flight access is abandoned; memory must tolerate the dropped request.
- Latency: a non-memory instruction appears in MEM/WB one cycle after it is present at the inputs. A memory instruction appears one cycle after the ack cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - WB-source encodings (WB_ALU=2'b00, WB_LOAD=2'b01, WB_LINK=2'b10);
  - FSM state typedef (IDLE/WAIT/ERR);
  - link offset constant 8.
- One natural sub-module, mem_wb_reg: the plain MEM/WB pipeline register with a bubble input. The handshake FSM and timeout counter stay in the top level.

Test Plan:
- ALU op, s_data_write=00, mem_c=0x1234, reg_write=1, rd=5, no mem_op → next cycle wb_wdata=0x1234, wb_num_write=5, wb_reg_write=1; dmem_req=0 and stall=0 throughout.
- Load at 0x100, ack after 3 wait cycles with rdata=0xDEADBEEF → stall=1 for 3 cycles with bubbles in WB; in the ack cycle stall=0; next cycle wb_wdata=0xDEADBEEF.
- Store at 0x200, data 0xCAFE, ack in the same cycle → dmem_we=1, dmem_addr=0x200, dmem_wdata=0xCAFE; stall never asserts; next cycle wb_reg_write=0.
- Load at 0x102 → dmem_req stays 0; misalign_err=1 and sticky; WB gets a bubble; the following ALU op writes back normally.
- Load with no ack, TIMEOUT=16 → stall held for 16 cycles, then bus_err=1, state ERR, stall=0; a subsequent load issues no request.
- Reset asserted in WAIT during a 5-cycle wait → next cycle dmem_req=0, all wb_*=0, errors=0; after reset deasserts, a new load is accepted and completes.
- Link op (s_data_write=10) with mem_pc=0xFFFFFFFC → wb_wdata=0x00000004 (wraps).
